// File: rtl/conv_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_ram_pkg
// Brief    : Shared constants and types for the convolution RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package conv_ram_pkg;

   localparam int CONV_RAM_DEPTH  = 16384;
   localparam int CONV_RAM_ADDR_W = 16;
   localparam int CONV_RAM_DATA_W = 8;

   localparam int REQ_HOST = 0;
   localparam int REQ_CONV = 1;
   localparam int REQ_WB   = 2;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin select, scanning upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import conv_ram_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   logic [IDX_W-1:0] w_cand;

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
      return IDX_W'((int'(p) + off) % NUM_REQ);
   endfunction

   // Offset NUM_REQ wraps back to ptr itself, so the last holder is checked last.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      valid  = 1'b0;
      w_cand = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_cand = wrap_idx(ptr, off);
         if (!valid && req[w_cand]) begin
            valid       = 1'b1;
            idx         = w_cand;
            gnt[w_cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : conv_ram_arbiter
// Brief    : Round-robin, burst-lockable arbiter for the single-port conv RAM.
// Revision : 1.0 - initial release
// ============================================================================
module conv_ram_arbiter
   import conv_ram_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int ADDR_W   = CONV_RAM_ADDR_W,
   parameter int DATA_W   = CONV_RAM_DATA_W,
   parameter int DEPTH    = CONV_RAM_DEPTH,
   parameter int MAX_LOCK = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ-1:0]        wr,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      err,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [DATA_W-1:0]         ram_data,
   output logic                      ram_wren,
   input  logic [DATA_W-1:0]         ram_q
);

   localparam int                 c_idx_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                 c_cnt_w    = $clog2(MAX_LOCK + 1);
   localparam logic [ADDR_W:0]    c_depth    = (ADDR_W + 1)'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_max_lock = c_cnt_w'(MAX_LOCK);
   localparam logic [c_idx_w-1:0] c_ptr_rst  = c_idx_w'(NUM_REQ - 1);
   localparam bit                 c_can_lock = (MAX_LOCK > 1);

   arb_state_t         r_state, w_state_nxt;
   logic [c_idx_w-1:0] r_owner, w_owner_nxt;
   logic [c_idx_w-1:0] r_rr_ptr, w_rr_ptr_nxt;
   logic [c_cnt_w-1:0] r_lock_cnt, w_lock_cnt_nxt, w_lock_cnt_inc;

   logic [NUM_REQ-1:0] r_rvalid;
   logic               r_rd_oor;
   logic               r_err;
   logic [ADDR_W-1:0]  r_last_addr;
   logic [DATA_W-1:0]  r_last_data;

   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [c_idx_w-1:0] w_pick_idx;
   logic               w_pick_valid;

   logic [NUM_REQ-1:0] w_gnt;
   logic               w_granted;
   logic               w_live;
   logic               w_owner_hit;
   logic [c_idx_w-1:0] w_winner;
   logic [ADDR_W-1:0]  w_win_addr;
   logic [DATA_W-1:0]  w_win_data;
   logic               w_win_wr;
   logic               w_in_range;

   logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
         assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_rr_pick (
      .req   (req),
      .ptr   (r_rr_ptr),
      .gnt   (w_pick_gnt),
      .idx   (w_pick_idx),
      .valid (w_pick_valid)
   );

   // A locked owner that drops req falls through to normal arbitration this cycle.
   assign w_owner_hit    = (r_state == LOCKED) && req[r_owner];
   assign w_lock_cnt_inc = r_lock_cnt + 1'b1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ARB;
         r_owner    <= '0;
         r_rr_ptr   <= c_ptr_rst;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_lock_cnt_nxt = r_lock_cnt;
      if (w_owner_hit) begin
         // Pointer already equals the owner, so a capped burst yields to the others.
         if (lock[r_owner] && (w_lock_cnt_inc < c_max_lock)) begin
            w_state_nxt    = LOCKED;
            w_lock_cnt_nxt = w_lock_cnt_inc;
         end else begin
            w_state_nxt    = ARB;
            w_lock_cnt_nxt = '0;
         end
      end else if (w_pick_valid) begin
         w_rr_ptr_nxt = w_pick_idx;
         if (lock[w_pick_idx] && c_can_lock) begin
            w_state_nxt    = LOCKED;
            w_owner_nxt    = w_pick_idx;
            w_lock_cnt_nxt = c_cnt_w'(1);
         end else begin
            w_state_nxt    = ARB;
            w_lock_cnt_nxt = '0;
         end
      end else begin
         w_state_nxt    = ARB;
         w_lock_cnt_nxt = '0;
      end
   end

   always_comb begin
      w_gnt     = '0;
      w_granted = 1'b0;
      w_winner  = r_owner;
      if (w_owner_hit) begin
         w_granted      = 1'b1;
         w_gnt[r_owner] = 1'b1;
      end else if (w_pick_valid) begin
         w_granted = 1'b1;
         w_winner  = w_pick_idx;
         w_gnt     = w_pick_gnt;
      end
   end

   assign w_win_addr = w_addr_arr[w_winner];
   assign w_win_data = w_wdata_arr[w_winner];
   assign w_win_wr   = wr[w_winner];
   assign w_in_range = ({1'b0, w_win_addr} < c_depth);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rvalid    <= '0;
         r_rd_oor    <= 1'b0;
         r_err       <= 1'b0;
         r_last_addr <= '0;
         r_last_data <= '0;
      end else begin
         r_rvalid <= (w_granted && !w_win_wr) ? w_gnt : '0;
         r_rd_oor <= w_granted && !w_win_wr && !w_in_range;
         if (w_granted && !w_in_range) begin
            r_err <= 1'b1;
         end
         if (w_granted) begin
            r_last_addr <= w_win_addr;
            r_last_data <= w_win_data;
         end
      end
   end

   // Ports are forced idle while reset is held, even with requests pending.
   assign w_live      = w_granted && reset_n;
   assign gnt         = reset_n ? w_gnt : '0;
   assign ram_address = w_live ? w_win_addr : r_last_addr;
   assign ram_data    = w_live ? w_win_data : r_last_data;
   assign ram_wren    = w_live && w_win_wr && w_in_range;
   assign rvalid      = r_rvalid;
   assign rdata       = r_rd_oor ? '0 : ram_q;
   assign err         = r_err;

endmodule
`default_nettype wire

// File: doc/conv_ram_arbiter.md
Name: conv_ram_arbiter

Overview:
- Shares the single-port 16K x 8 convolution RAM between NUM_REQ requesters: host loader, conv engine reads, result writeback.
- Grants at most one access per clock, round-robin, with bounded burst locking.
- Muxes the winner's address, data and write enable onto the RAM port.
- Returns read data with a per-requester valid, 1 cycle after grant, matching the RAM's registered read.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 = host, 1 = conv engine, 2 = writeback.
- ADDR_W, 16: address width presented by requesters and to the RAM.
- DATA_W, 8: data width.
- DEPTH, 16384: valid RAM words; addresses >= DEPTH are out of range.
- MAX_LOCK, 16: maximum consecutive grants one requester may hold through lock.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request, level.
- lock  in  NUM_REQ  request to keep the grant for the next cycle (burst).
- wr  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted access.
- rvalid  out  NUM_REQ  registered; read data valid for requester i.
- rdata  out  DATA_W  read data, shared bus, qualified by rvalid.
- err  out  1  sticky out-of-range flag.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_W  from RAM q (valid 1 cycle after address).

Behaviour:
- Reset (async, reset_n = 0):
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - owner = none, lock_cnt = 0, state = ARB.
  - rvalid = 0, err = 0, gnt = 0.
  - ram_wren = 0; ram_address and ram_data = 0.
- An access completes in the cycle where req[i] and gnt[i] are both 1. The requester holds addr, wr and wdata stable while req is high and ungranted. No bypass: a read and a write in different cycles to the same address see the RAM's ordering.
- State ARB: gnt goes to the first asserted req scanning from rr_ptr+1 upward, modulo NUM_REQ.
  - On grant to i: rr_ptr <= i.
  - If lock[i] is 1: state <= LOCKED, owner <= i, lock_cnt <= 1.
  - If no req is asserted, there is no grant and no RAM access (ram_wren = 0).
- State LOCKED: only the owner may be granted.
  - req[owner] = 1: grant it and lock_cnt increments.
  - req[owner] = 0: return to ARB in the same cycle. Arbitration then runs combinationally that cycle, so no bubble is inserted.
  - lock[owner] = 0 on a granted access: that access is the last; next state = ARB.
  - lock_cnt reaches MAX_LOCK: the lock is ignored, next state = ARB, and rr_ptr = owner, so other requesters win first.
- RAM mux: ram_address = addr[winner], ram_data = wdata[winner], ram_wren = wr[winner] & in_range.
  - in_range = (addr < DEPTH).
  - When there is no grant: ram_wren = 0 and the address holds its last value.
- Read return: a granted read sets rvalid[i] = 1 in the next cycle, with rdata = ram_q.
  - Out-of-range read: rvalid still pulses, rdata = 0.
  - Writes never produce rvalid.
  - rvalid is 1 for exactly one cycle per granted read.
- Out of range: any granted access with addr >= DEPTH sets err = 1 on the next edge, and the write is suppressed. err clears only on reset.
- Back-to-back reads: one grant per cycle yields one rvalid per cycle, so throughput is 1 access/cycle.
- Reset mid-burst: an in-flight rvalid is dropped and the lock is released.

Decomposition:
- Shared package conv_ram_pkg holds:
  - CONV_RAM_DEPTH = 16384, CONV_RAM_ADDR_W = 16, CONV_RAM_DATA_W = 8.
  - Requester index constants REQ_HOST = 0, REQ_CONV = 1, REQ_WB = 2.
  - State enum {ARB, LOCKED}.
- One sub-module, rr_pick: combinational round-robin priority select.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant plus binary index.
- The arbiter instantiates rr_pick and holds the FSM, lock counter, mux and read-return pipeline. It does not instantiate the RAM; the testbench wires conv_ram to the ram_* ports.

Test Plan:
- Reset release, then req = 3'b111, all reads, lock = 0 -> grants cycle 0,1,2,0,... one per clock; rvalid follows each grant by 1 cycle with preloaded data.
- Host writes 0xA5 to address 0x0010, then the conv engine reads 0x0010 two cycles later -> rvalid[1] = 1 with rdata = 0xA5 exactly 1 cycle after gnt[1].
- Writeback holds lock and req for 20 cycles while host req = 1 -> gnt[2] for 16 consecutive cycles, then gnt[0] for one cycle, then writeback is granted again.
- Lock owner drops req mid-burst while the conv engine is requesting -> gnt[1] in the same cycle, with no idle cycle.
- Host write to 0x4000 with data 0xFF -> ram_wren = 0, err = 1 next cycle; a following read of 0x4000 -> rvalid with rdata = 0x00.
- Assert reset_n = 0 one cycle after a granted read -> rvalid stays 0, gnt = 0 immediately; after release, requester 0 wins first.
